// File: rtl/cbrt_param.sv
// ============================================================================
// Module   : cbrt_param
// Brief    : Multi-cycle floor cube root with remainder; all arithmetic on an external adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cbrt_param #(
   parameter  int WIDTH = 8,
   localparam int RW    = (WIDTH + 2) / 3,
   localparam int DW    = 3 * RW + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x_i,
   output logic             busy,
   output logic             done,
   output logic [RW-1:0]    result,
   output logic [WIDTH-1:0] remainder,
   output logic [DW-1:0]    sum_in_a,
   output logic [DW-1:0]    sum_in_b,
   input  logic [DW-1:0]    sum_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_DOUBLE, S_CAND, S_CMP, S_ACC, S_NEXT, S_FINISH
   } state_t;

   localparam logic [DW-1:0] C_S0     = DW'(3 * (RW - 1));
   localparam logic [DW-1:0] C_ONE    = DW'(1);
   localparam logic [DW-1:0] C_MINUS3 = {{(DW-2){1'b1}}, 2'b01};

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_ph;
   logic [DW-1:0]    r_xr;
   logic [DW-1:0]    r_y2;
   logic [DW-1:0]    r_b;
   logic [DW-1:0]    r_d;
   logic [DW-1:0]    r_s;
   logic [RW-1:0]    r_y;
   logic [RW-1:0]    r_result;
   logic [WIDTH-1:0] r_rem;
   logic [DW-1:0]    w_y_ext;

   assign w_y_ext   = {{(DW-RW){1'b0}}, r_y};
   assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign done      = (r_state == S_FINISH);
   assign result    = r_result;
   assign remainder = r_rem;

   // Candidate is built as t=y2+y, 3t=2t+t, (3t+1)<<s; trial subtract is xr+~b then +1.
   always_comb begin
      w_next   = r_state;
      sum_in_a = '0;
      sum_in_b = '0;
      unique case (r_state)
         S_IDLE:   if (start) w_next = S_INIT;
         S_INIT:   w_next = S_DOUBLE;
         S_DOUBLE: w_next = S_CAND;
         S_CAND: begin
            if (r_ph[1]) begin
               sum_in_a = r_b;
               sum_in_b = C_ONE;
               w_next   = S_CMP;
            end else if (r_ph[0]) begin
               sum_in_a = {r_b[DW-2:0], 1'b0};
               sum_in_b = r_b;
            end else begin
               sum_in_a = r_y2;
               sum_in_b = w_y_ext;
            end
         end
         S_CMP: begin
            if (r_ph[0]) begin
               sum_in_a = r_d;
               sum_in_b = C_ONE;
               w_next   = S_ACC;
            end else begin
               sum_in_a = r_xr;
               sum_in_b = ~r_b;
            end
         end
         S_ACC: begin
            // y is even after doubling, so 2y+1 is a shift with a forced LSB
            sum_in_a = r_y2;
            sum_in_b = {w_y_ext[DW-2:0], 1'b1};
            w_next   = S_NEXT;
         end
         S_NEXT: begin
            sum_in_a = r_s;
            sum_in_b = C_MINUS3;
            w_next   = sum_out[DW-1] ? S_FINISH : S_DOUBLE;
         end
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_ph     <= '0;
         r_xr     <= '0;
         r_y2     <= '0;
         r_b      <= '0;
         r_d      <= '0;
         r_s      <= '0;
         r_y      <= '0;
         r_result <= '0;
         r_rem    <= '0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_xr <= DW'(x_i);
                  r_y  <= '0;
                  r_y2 <= '0;
                  r_s  <= C_S0;
               end
            end
            S_DOUBLE: begin
               r_y  <= {r_y[RW-2:0], 1'b0};
               r_y2 <= {r_y2[DW-3:0], 2'b00};
               r_ph <= '0;
            end
            S_CAND: begin
               if (r_ph[1]) begin
                  r_b  <= sum_out << r_s;
                  r_ph <= '0;
               end else begin
                  r_b  <= sum_out;
                  r_ph <= {r_ph[0], 1'b1};
               end
            end
            S_CMP: begin
               r_d  <= sum_out;
               r_ph <= r_ph[0] ? 2'b00 : 2'b01;
            end
            S_ACC: begin
               if (!r_d[DW-1]) begin
                  r_xr   <= r_d;
                  r_y2   <= sum_out;
                  r_y[0] <= 1'b1;
               end
            end
            S_NEXT: begin
               r_s <= sum_out;
               // Results are loaded on entry to FINISH so they are valid with done
               if (sum_out[DW-1]) begin
                  r_result <= r_y;
                  r_rem    <= r_xr[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cbrt_param.sv
// ============================================================================
// Module   : tb_cbrt_param
// Brief    : Self-checking bench for cbrt_param at WIDTH=8 and WIDTH=16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cbrt_param;

   logic        clk = 1'b0;
   logic        rst8, rst16;
   logic        st8, st16;
   logic [7:0]  x8;
   logic [15:0] x16;
   logic        busy8, done8, busy16, done16;
   logic [2:0]  res8;
   logic [5:0]  res16;
   logic [7:0]  rem8;
   logic [15:0] rem16;
   logic [10:0] a8, b8, s8;
   logic [19:0] a16, b16, s16;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign s8  = a8 + b8;
   assign s16 = a16 + b16;

   cbrt_param #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(st8), .x_i(x8),
      .busy(busy8), .done(done8), .result(res8), .remainder(rem8),
      .sum_in_a(a8), .sum_in_b(b8), .sum_out(s8)
   );

   cbrt_param #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst16), .start(st16), .x_i(x16),
      .busy(busy16), .done(done16), .result(res16), .remainder(rem16),
      .sum_in_a(a16), .sum_in_b(b16), .sum_out(s16)
   );

   typedef struct {
      int x;
      int r;
      int rm;
   } vec_t;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_le(input string nm, input longint act, input longint lim);
      total++;
      if (act > lim) begin
         bad++;
         $display("FAIL %s: got %0d limit %0d", nm, act, lim);
      end
   endtask

   // Reference: largest r with r^3 <= x, found by plain search.
   function automatic void ref_cbrt(input longint x, output longint r, output longint rm);
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
      rm = x - r * r * r;
   endfunction

   // One start pulse, then count busy cycles and capture outputs on the done cycle.
   task automatic run_op(input bit w16, input int x, output int r, output int rm,
                         output int nb, output int d1, output int d2, output int az);
      @(negedge clk);
      if (w16) begin x16 = x[15:0]; st16 = 1'b1; end
      else     begin x8  = x[7:0];  st8  = 1'b1; end
      @(negedge clk);
      st8  = 1'b0;
      st16 = 1'b0;
      nb   = 0;
      while ((w16 ? busy16 : busy8) && nb < 200) begin
         nb++;
         @(negedge clk);
      end
      d1 = w16 ? int'(done16) : int'(done8);
      r  = w16 ? int'(res16)  : int'(res8);
      rm = w16 ? int'(rem16)  : int'(rem8);
      az = w16 ? int'(a16 == '0 && b16 == '0) : int'(a8 == '0 && b8 == '0);
      @(negedge clk);
      d2 = w16 ? int'(done16) : int'(done8);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   tbl[9];
      int     r, rm, nb, d1, d2, az, nb0, nb16;
      int     nd, chg, idle, gaps, badgap, badr, seen;
      longint er, erm;

      tbl[0] = '{27, 3, 0};   tbl[1] = '{64, 4, 0};   tbl[2] = '{125, 5, 0};
      tbl[3] = '{216, 6, 0};  tbl[4] = '{8, 2, 0};    tbl[5] = '{0, 0, 0};
      tbl[6] = '{1, 1, 0};    tbl[7] = '{7, 1, 6};    tbl[8] = '{255, 6, 39};

      rst8 = 1'b0; rst16 = 1'b0; st8 = 1'b0; st16 = 1'b0; x8 = '0; x16 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_result8", res8, 0);
      check("rst_rem8", rem8, 0);
      check("rst_adder8", a8 | b8, 0);
      check("rst_busy16", busy16, 0);
      check("rst_result16", res16, 0);
      rst8 = 1'b1; rst16 = 1'b1;

      nb0 = -1;
      foreach (tbl[i]) begin
         run_op(1'b0, tbl[i].x, r, rm, nb, d1, d2, az);
         check($sformatf("res8_x%0d", tbl[i].x), r, tbl[i].r);
         check($sformatf("rem8_x%0d", tbl[i].x), rm, tbl[i].rm);
         check($sformatf("done8_x%0d", tbl[i].x), d1, 1);
         check($sformatf("done8_once_x%0d", tbl[i].x), d2, 0);
         check($sformatf("adder_idle8_x%0d", tbl[i].x), az, 1);
         check_le($sformatf("busy8_len_x%0d", tbl[i].x), nb, 26);
         if (nb0 < 0) nb0 = nb;
         check($sformatf("busy8_const_x%0d", tbl[i].x), nb, nb0);
      end

      for (int x = 0; x < 256; x++) begin
         run_op(1'b0, x, r, rm, nb, d1, d2, az);
         ref_cbrt(x, er, erm);
         check($sformatf("sweep_res_x%0d", x), r, er);
         check($sformatf("sweep_rem_x%0d", x), rm, erm);
      end

      // Second start mid-operation must be ignored; result holds the old value meanwhile.
      run_op(1'b0, 64, r, rm, nb, d1, d2, az);
      @(negedge clk); x8 = 8'd125; st8 = 1'b1;
      @(negedge clk); st8 = 1'b0;
      nb = 0; nd = 0; chg = 0; r = -1; rm = -1;
      for (int i = 0; i < 40; i++) begin
         if (busy8) nb++;
         if (done8) begin nd++; r = res8; rm = rem8; end
         if (busy8 && res8 != 3'd4) chg++;
         if (busy8 && nb == 5) begin st8 = 1'b1; x8 = 8'd8; end
         else st8 = 1'b0;
         @(negedge clk);
      end
      check("ignore_dones", nd, 1);
      check("ignore_res", r, 5);
      check("ignore_rem", rm, 0);
      check("hold_result_while_busy", chg, 0);
      check("ignore_busy_len", nb, nb0);

      // Asynchronous reset mid-operation.
      @(negedge clk); x8 = 8'd216; st8 = 1'b1;
      @(negedge clk); st8 = 1'b0;
      nb = 0;
      while (busy8 && nb < 10) begin nb++; @(negedge clk); end
      check("abort_reached_cycle10", nb, 10);
      rst8 = 1'b0;
      #1;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_result", res8, 0);
      check("abort_rem", rem8, 0);
      check("abort_adder", a8 | b8, 0);
      nd = 0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); nd += int'(done8); end
      rst8 = 1'b1;
      for (int i = 0; i < 30; i++) begin @(negedge clk); nd += int'(done8); end
      check("abort_no_done", nd, 0);
      run_op(1'b0, 64, r, rm, nb, d1, d2, az);
      check("after_abort_res", r, 4);
      check("after_abort_rem", rm, 0);

      // Start held high: back-to-back operations with FINISH plus one IDLE cycle between.
      @(negedge clk); x8 = 8'd27; st8 = 1'b1;
      nd = 0; badr = 0; idle = 0; gaps = 0; badgap = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done8) begin
            nd++;
            if (res8 != 3'd3 || rem8 != 8'd0) badr++;
         end
         if (busy8) begin
            if (seen != 0 && idle > 0) begin
               gaps++;
               if (idle != 2) badgap++;
            end
            idle = 0;
            seen = 1;
         end else if (seen != 0) idle++;
      end
      st8 = 1'b0;
      check("b2b_dones_ge3", int'(nd >= 3), 1);
      check("b2b_results", badr, 0);
      check("b2b_gaps_seen_ge2", int'(gaps >= 2), 1);
      check("b2b_gap_len", badgap, 0);
      nb = 0;
      while (busy8 && nb < 200) begin nb++; @(negedge clk); end

      // WIDTH=16 corners and random operands.
      run_op(1'b1, 65535, r, rm, nb16, d1, d2, az);
      check("res16_max", r, 40);
      check("rem16_max", rm, 1535);
      check("done16_max", d1, 1);
      check_le("busy16_len", nb16, 50);
      run_op(1'b1, 64000, r, rm, nb, d1, d2, az);
      check("res16_64000", r, 40);
      check("rem16_64000", rm, 0);
      check("busy16_const", nb, nb16);
      for (int i = 0; i < 20; i++) begin
         int x;
         x = int'($urandom_range(65535, 0));
         run_op(1'b1, x, r, rm, nb, d1, d2, az);
         ref_cbrt(x, er, erm);
         check($sformatf("rand16_res_x%0d", x), r, er);
         check($sformatf("rand16_rem_x%0d", x), rm, erm);
         check($sformatf("rand16_busy_x%0d", x), nb, nb16);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
